// File: rtl/oflow_iou_sched_if.sv
// Bundle of history-write, request, IoU-engine and result signals for oflow_iou_sched.
// Field widths come from the legacy range macros BBOX_POSITION_FRAME, WIDTH_LEN, HEIGHT_LEN and IOU_LEN.
`ifndef BBOX_POSITION_FRAME
`define BBOX_POSITION_FRAME 39:0
`endif
`ifndef WIDTH_LEN
`define WIDTH_LEN 9:0
`endif
`ifndef HEIGHT_LEN
`define HEIGHT_LEN 9:0
`endif
`ifndef IOU_LEN
`define IOU_LEN 21:0
`endif

interface oflow_iou_sched_if #(
  parameter int IDX_W = 3
);
  logic                        hist_wr_en;
  logic [IDX_W-1:0]            hist_wr_idx;
  logic                        hist_wr_clr;
  logic [`BBOX_POSITION_FRAME] hist_pos;
  logic [`WIDTH_LEN]           hist_w;
  logic [`HEIGHT_LEN]          hist_h;

  logic                        req_valid;
  logic                        req_ready;
  logic [`BBOX_POSITION_FRAME] req_pos;
  logic [`WIDTH_LEN]           req_w;
  logic [`HEIGHT_LEN]          req_h;
  logic [`IOU_LEN]             iou_thresh;

  logic                        iou_start;
  logic [`BBOX_POSITION_FRAME] bbox_position_frame_k;
  logic [`BBOX_POSITION_FRAME] bbox_position_frame_history;
  logic [`WIDTH_LEN]           bbox_w_frame_k;
  logic [`WIDTH_LEN]           bbox_w_frame_history;
  logic [`HEIGHT_LEN]          bbox_h_frame_k;
  logic [`HEIGHT_LEN]          bbox_h_frame_history;
  logic                        valid_iou;
  logic [`IOU_LEN]             iou;

  logic                        res_valid;
  logic                        res_ready;
  logic [IDX_W-1:0]            res_idx;
  logic [`IOU_LEN]             res_iou;
  logic                        res_match;
  logic                        res_err;

  modport slave (
    input  hist_wr_en, hist_wr_idx, hist_wr_clr, hist_pos, hist_w, hist_h,
    input  req_valid, req_pos, req_w, req_h, iou_thresh,
    output req_ready,
    output iou_start, bbox_position_frame_k, bbox_position_frame_history,
    output bbox_w_frame_k, bbox_w_frame_history, bbox_h_frame_k, bbox_h_frame_history,
    input  valid_iou, iou,
    output res_valid, res_idx, res_iou, res_match, res_err,
    input  res_ready
  );

  modport master (
    output hist_wr_en, hist_wr_idx, hist_wr_clr, hist_pos, hist_w, hist_h,
    output req_valid, req_pos, req_w, req_h, iou_thresh,
    input  req_ready,
    input  iou_start, bbox_position_frame_k, bbox_position_frame_history,
    input  bbox_w_frame_k, bbox_w_frame_history, bbox_h_frame_k, bbox_h_frame_history,
    output valid_iou, iou,
    input  res_valid, res_idx, res_iou, res_match, res_err,
    output res_ready
  );
endinterface

// File: rtl/oflow_iou_sched.sv
// Scans the history bbox table, runs the IoU engine once per valid slot and reports the lowest-IoU slot.
// Optional WAIT watchdog selected by macro OFLOW_IOU_SCHED_TIMEOUT_EN (res_err tied low when undefined).
`ifndef BBOX_POSITION_FRAME
`define BBOX_POSITION_FRAME 39:0
`endif
`ifndef WIDTH_LEN
`define WIDTH_LEN 9:0
`endif
`ifndef HEIGHT_LEN
`define HEIGHT_LEN 9:0
`endif
`ifndef IOU_LEN
`define IOU_LEN 21:0
`endif

module oflow_iou_sched #(
  parameter int NUM_HIST    = 8,
  parameter int IDX_W       = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input logic              clk,
  input logic              reset,
  oflow_iou_sched_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SCAN  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]                  state;
  // Extra MSB lets the scan terminate at NUM_HIST without wrapping to slot 0
  logic [IDX_W:0]              ptr;
  logic [IDX_W-1:0]            slot;

  logic [NUM_HIST-1:0]         hist_vld;
  logic [`BBOX_POSITION_FRAME] hist_pos_mem [NUM_HIST];
  logic [`WIDTH_LEN]           hist_w_mem   [NUM_HIST];
  logic [`HEIGHT_LEN]          hist_h_mem   [NUM_HIST];

  logic [`BBOX_POSITION_FRAME] k_pos;
  logic [`WIDTH_LEN]           k_w;
  logic [`HEIGHT_LEN]          k_h;
  logic [`IOU_LEN]             thresh;
  logic [`IOU_LEN]             best_iou;
  logic [IDX_W-1:0]            best_idx;
  logic                        found;
  logic                        hist_wr;

`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC != 0);
`endif

  assign slot    = ptr[IDX_W-1:0];
  assign hist_wr = (state == IDLE) && bus.hist_wr_en;

  // Table payload carries no reset; only the valid bits matter after reset
  always_ff @(posedge clk) begin
    if (hist_wr && !bus.hist_wr_clr) begin
      hist_pos_mem[bus.hist_wr_idx] <= bus.hist_pos;
      hist_w_mem[bus.hist_wr_idx]   <= bus.hist_w;
      hist_h_mem[bus.hist_wr_idx]   <= bus.hist_h;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      hist_vld <= '0;
      best_iou <= '1;
      best_idx <= '0;
      found    <= 1'b0;
      k_pos    <= '0;
      k_w      <= '0;
      k_h      <= '0;
      thresh   <= '0;
`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
      wd_cnt   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hist_wr) hist_vld[bus.hist_wr_idx] <= !bus.hist_wr_clr;
          if (bus.req_valid) begin
            k_pos    <= bus.req_pos;
            k_w      <= bus.req_w;
            k_h      <= bus.req_h;
            thresh   <= bus.iou_thresh;
            ptr      <= '0;
            best_iou <= '1;
            best_idx <= '0;
            found    <= 1'b0;
`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (ptr[IDX_W]) begin
            state <= DONE;
          end else if (hist_vld[slot]) begin
            found <= 1'b1;
            state <= ISSUE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ISSUE: begin
`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // Strict compare keeps the earliest slot on equal IoU
          if (bus.valid_iou) begin
            if (bus.iou < best_iou) begin
              best_iou <= bus.iou;
              best_idx <= slot;
            end
            ptr   <= ptr + 1'b1;
            state <= SCAN;
          end
`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            err_q <= 1'b1;
            ptr   <= ptr + 1'b1;
            state <= SCAN;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operands hold from ISSUE through WAIT: ptr is frozen and table writes are blocked outside IDLE
  assign bus.bbox_position_frame_k       = k_pos;
  assign bus.bbox_w_frame_k              = k_w;
  assign bus.bbox_h_frame_k              = k_h;
  assign bus.bbox_position_frame_history = hist_pos_mem[slot];
  assign bus.bbox_w_frame_history        = hist_w_mem[slot];
  assign bus.bbox_h_frame_history        = hist_h_mem[slot];

  assign bus.req_ready = (state == IDLE);
  assign bus.iou_start = (state == ISSUE);
  assign bus.res_valid = (state == DONE);
  assign bus.res_idx   = best_idx;
  assign bus.res_iou   = best_iou;
  assign bus.res_match = found && (best_iou <= thresh);
`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
  assign bus.res_err   = err_q;
`else
  assign bus.res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_oflow_iou_sched.sv
// Randomized scoreboard bench for oflow_iou_sched: a table model predicts each result, an engine model answers iou_start.
`ifndef BBOX_POSITION_FRAME
`define BBOX_POSITION_FRAME 39:0
`endif
`ifndef WIDTH_LEN
`define WIDTH_LEN 9:0
`endif
`ifndef HEIGHT_LEN
`define HEIGHT_LEN 9:0
`endif
`ifndef IOU_LEN
`define IOU_LEN 21:0
`endif

module tb_oflow_iou_sched;
  localparam int N  = 8;
  localparam int IW = 3;

  typedef logic [`IOU_LEN] iou_t;
  typedef struct {
    logic [IW-1:0] idx;
    iou_t          iou;
    logic          match;
    logic          err;
    int            nstart;
    int            acc;
  } exp_t;
  typedef struct {
    int   slot;
    iou_t iou;
    bit   drop;
  } eng_t;

  logic clk = 1'b0;
  logic reset;
  oflow_iou_sched_if #(.IDX_W(IW)) bus ();
  oflow_iou_sched #(.NUM_HIST(N), .IDX_W(IW), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0, errors = 0;
  int   starts = 0, resp_cnt = 0, issued = 0;
  int   next_hold = -1, busy_idx = -1;
  exp_t exp_q[$];
  eng_t eng_q[$];

  bit                          mv   [N];
  logic [`BBOX_POSITION_FRAME] mpos [N];
  logic [`WIDTH_LEN]           mw   [N];
  logic [`HEIGHT_LEN]          mh   [N];
  iou_t                        force_iou  [N];
  bit                          force_drop [N];
  logic [`BBOX_POSITION_FRAME] cur_kpos;
  logic [`WIDTH_LEN]           cur_kw;
  logic [`HEIGHT_LEN]          cur_kh;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic iou_t rand_iou();
    return iou_t'($urandom_range(0, 15)) << 18;
  endfunction

  task automatic hist_write(input int idx, input bit clr);
    logic [`BBOX_POSITION_FRAME] p;
    logic [`WIDTH_LEN] w;
    logic [`HEIGHT_LEN] h;
    p = 40'({$urandom(), $urandom()});
    w = 10'($urandom());
    h = 10'($urandom());
    bus.hist_wr_en = 1'b1; bus.hist_wr_idx = IW'(idx); bus.hist_wr_clr = clr;
    bus.hist_pos = p; bus.hist_w = w; bus.hist_h = h;
    tick();
    bus.hist_wr_en = 1'b0;
    if (clr) mv[idx] = 1'b0;
    else begin
      mv[idx] = 1'b1; mpos[idx] = p; mw[idx] = w; mh[idx] = h;
    end
  endtask

  task automatic start_req(input iou_t thr, output int acc);
    int t;
    cur_kpos = 40'({$urandom(), $urandom()});
    cur_kw = 10'($urandom());
    cur_kh = 10'($urandom());
    bus.req_pos = cur_kpos; bus.req_w = cur_kw; bus.req_h = cur_kh;
    bus.iou_thresh = thr; bus.req_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_before_accept", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    acc = cyc;
  endtask

  // mode 0: random engine answers; mode 1: answers taken from force_iou/force_drop
  task automatic do_request(input int mode, input iou_t thr);
    exp_t e;
    eng_t g;
    iou_t best;
    int   bidx, n, acc, t;
    bit   any, err;
    start_req(thr, acc);
    best = '1; bidx = 0; n = 0; any = 0; err = 0;
    for (int s = 0; s < N; s++) begin
      if (mv[s]) begin
        n++; any = 1;
        g.slot = s;
        g.iou  = (mode == 1) ? force_iou[s] : rand_iou();
`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
        g.drop = (mode == 1) ? force_drop[s] : ($urandom_range(0, 7) == 0);
`else
        g.drop = 1'b0;
`endif
        eng_q.push_back(g);
        if (g.drop) err = 1;
        else if (g.iou < best) begin best = g.iou; bidx = s; end
      end
    end
    e.idx = IW'(bidx); e.iou = best; e.match = any && (best <= thr);
    e.err = err; e.nstart = n; e.acc = acc;
    exp_q.push_back(e);
    issued++;
    // Table writes while busy must be ignored, so the model is left untouched
    t = 0;
    while (resp_cnt < issued && t < 3000) begin
      bus.hist_wr_en  = !bus.res_ready && ($urandom_range(0, 2) == 0);
      bus.hist_wr_idx = (busy_idx >= 0) ? IW'(busy_idx) : IW'($urandom_range(0, N - 1));
      bus.hist_wr_clr = ($urandom_range(0, 3) == 0);
      bus.hist_pos    = 40'({$urandom(), $urandom()});
      bus.hist_w      = 10'($urandom());
      bus.hist_h      = 10'($urandom());
      tick();
      t++;
    end
    bus.hist_wr_en = 1'b0;
    chk("result_delivered", resp_cnt >= issued, 1'b1);
  endtask

  // IoU engine model
  initial begin
    eng_t e;
    int d;
    bus.valid_iou = 1'b0;
    bus.iou = '0;
    forever begin
      @(negedge clk);
      if (bus.iou_start === 1'b1) begin
        starts++;
        if (eng_q.size() == 0) chk("unexpected_iou_start", 1'b1, 1'b0);
        else begin
          e = eng_q.pop_front();
          chk("k_pos", bus.bbox_position_frame_k, cur_kpos);
          chk("k_wh", {bus.bbox_w_frame_k, bus.bbox_h_frame_k}, {cur_kw, cur_kh});
          chk("hist_pos", bus.bbox_position_frame_history, mpos[e.slot]);
          chk("hist_wh", {bus.bbox_w_frame_history, bus.bbox_h_frame_history},
              {mw[e.slot], mh[e.slot]});
          tick();
          chk("iou_start_one_cycle", bus.iou_start, 1'b0);
          if (!e.drop) begin
            d = $urandom_range(0, 4);
            repeat (d) tick();
            chk("hist_pos_stable", bus.bbox_position_frame_history, mpos[e.slot]);
            bus.valid_iou = 1'b1;
            bus.iou = e.iou;
            tick();
            // Stray answer after WAIT has ended must be ignored
            if ($urandom_range(0, 1) == 1) begin
              bus.iou = '0;
              tick();
            end
            bus.valid_iou = 1'b0;
            bus.iou = rand_iou();
          end
        end
      end
    end
  end

  // Result monitor
  initial begin
    exp_t e;
    int hold;
    bus.res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1'b1, 1'b0);
          e.idx = '0; e.iou = '1; e.match = 0; e.err = 0; e.nstart = 0; e.acc = cyc;
        end else e = exp_q.pop_front();
        chk("res_idx", bus.res_idx, e.idx);
        chk("res_iou", bus.res_iou, e.iou);
        chk("res_match", bus.res_match, e.match);
        chk("res_err", bus.res_err, e.err);
        chk("iou_start_count", starts, e.nstart);
        chk("req_ready_in_done", bus.req_ready, 1'b0);
        if (e.nstart == 0) chk("empty_scan_latency", (cyc - e.acc) <= N + 2, 1'b1);
        hold = (next_hold >= 0) ? next_hold : $urandom_range(0, 4);
        next_hold = -1;
        repeat (hold) begin
          @(negedge clk);
          chk("hold_valid", bus.res_valid, 1'b1);
          chk("hold_result", {bus.res_idx, bus.res_iou, bus.res_match}, {e.idx, e.iou, e.match});
          chk("hold_req_ready", bus.req_ready, 1'b0);
        end
        bus.res_ready = 1'b1;
        chk("req_ready_on_handshake", bus.req_ready, 1'b0);
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("idle_after_handshake", {bus.res_valid, bus.req_ready}, 2'b01);
        starts = 0;
        resp_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=hang required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int acc, t;
    eng_t g;
    bus.hist_wr_en = 1'b0; bus.hist_wr_idx = '0; bus.hist_wr_clr = 1'b0;
    bus.hist_pos = '0; bus.hist_w = '0; bus.hist_h = '0;
    bus.req_valid = 1'b0; bus.req_pos = '0; bus.req_w = '0; bus.req_h = '0; bus.iou_thresh = '0;
    for (int s = 0; s < N; s++) begin mv[s] = 0; force_iou[s] = '1; force_drop[s] = 0; end
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_outputs", {bus.req_ready, bus.iou_start, bus.res_valid, bus.res_match, bus.res_err},
        5'b10000);

    // Empty table
    do_request(0, rand_iou());

    // Slots 0,2,5 with a tie on the later two
    hist_write(0, 0); hist_write(2, 0); hist_write(5, 0);
    force_iou[0] = 22'h100000; force_iou[2] = 22'h080000; force_iou[5] = 22'h080000;
    do_request(1, 22'h200000);

    // Single slot above threshold, result held for 5 cycles
    hist_write(2, 1); hist_write(5, 1);
    force_iou[0] = 22'h300000;
    next_hold = 5;
    do_request(1, 22'h200000);

    // Writes to slot 3 while busy are dropped
    busy_idx = 3;
    do_request(0, rand_iou());
    busy_idx = -1;
    do_request(0, rand_iou());

`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
    hist_write(1, 0); hist_write(2, 0);
    force_iou[0] = 22'h200000; force_iou[1] = 22'h000000; force_iou[2] = 22'h100000;
    force_drop[1] = 1;
    do_request(1, 22'h200000);
    force_drop[1] = 0;
`endif

    for (int i = 0; i < 25; i++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int k = 0; k < nw; k++) hist_write($urandom_range(0, N - 1), $urandom_range(0, 3) == 0);
      do_request(0, rand_iou());
    end

    // Reset while waiting on the second slot
    for (int s = 0; s < N; s++) hist_write(s, 1);
    hist_write(0, 0); hist_write(1, 0);
    start_req(22'h200000, acc);
    g.slot = 0; g.iou = rand_iou(); g.drop = 0; eng_q.push_back(g);
    g.slot = 1; g.iou = '0;         g.drop = 1; eng_q.push_back(g);
    t = 0;
    while (starts < 2 && t < 200) begin tick(); t++; end
    chk("second_slot_issued", starts, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_wait", {bus.req_ready, bus.iou_start, bus.res_valid, bus.res_err}, 4'b1000);
    for (int s = 0; s < N; s++) mv[s] = 0;
    eng_q.delete();
    starts = 0;
    do_request(0, rand_iou());

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size() + eng_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oflow_iou_sched.md
OFLOW_IOU_SCHED -- requirements
Module: oflow_iou_sched

Interface
REQ-001 The block SHALL have parameter NUM_HIST, default 8, the number of history bbox slots (power of two, 2..32).
REQ-002 The block SHALL have parameter IDX_W, default 3, equal to log2(NUM_HIST).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 64, the watchdog limit in cycles (used only under REQ-025).
REQ-004 The block SHALL have ports clk (in, 1, sole clock) and reset (in, 1, synchronous active-high reset).
REQ-005 The block SHALL have history write ports hist_wr_en (in, 1), hist_wr_idx (in, IDX_W), hist_wr_clr (in, 1, invalidates the slot instead of writing it), hist_pos (in, `BBOX_POSITION_FRAME, {X_TL,Y_TL,X_BR,Y_BR}), hist_w (in, `WIDTH_LEN) and hist_h (in, `HEIGHT_LEN).
REQ-006 The block SHALL have request ports req_valid (in, 1), req_ready (out, 1), req_pos (in, `BBOX_POSITION_FRAME), req_w (in, `WIDTH_LEN), req_h (in, `HEIGHT_LEN) and iou_thresh (in, `IOU_LEN, sampled on request accept).
REQ-007 The block SHALL have IoU-engine ports iou_start (out, 1), bbox_position_frame_k/bbox_position_frame_history (out, `BBOX_POSITION_FRAME), bbox_w_frame_k/bbox_w_frame_history (out, `WIDTH_LEN), bbox_h_frame_k/bbox_h_frame_history (out, `HEIGHT_LEN), valid_iou (in, 1) and iou (in, `IOU_LEN).
REQ-008 The block SHALL have result ports res_valid (out, 1), res_ready (in, 1), res_idx (out, IDX_W), res_iou (out, `IOU_LEN), res_match (out, 1) and res_err (out, 1).

Function
REQ-009 The block SHALL store NUM_HIST entries of {valid, pos, w, h}; hist_wr_en in IDLE writes slot hist_wr_idx and sets valid, or clears valid when hist_wr_clr=1.
REQ-010 The block SHALL ignore hist_wr_en in any state other than IDLE.
REQ-011 The FSM SHALL have states IDLE, SCAN, ISSUE, WAIT and DONE.
REQ-012 In IDLE, req_ready SHALL be 1; a request is accepted on req_valid&&req_ready, latching req_pos/w/h and iou_thresh, clearing the slot pointer to 0, setting best_iou to all-ones, and moving to SCAN.
REQ-013 In SCAN, the block SHALL skip invalid slots one per cycle; it goes to ISSUE on a valid slot and to DONE once the pointer passes NUM_HIST-1.
REQ-014 In ISSUE, iou_start SHALL be 1 for exactly one cycle, followed by WAIT.
REQ-015 The k-frame and history operand outputs SHALL stay stable from the ISSUE cycle through the cycle valid_iou is sampled.
REQ-016 In WAIT, on valid_iou=1 the block SHALL update best_iou/best_idx only if iou < best_iou (strict, so the lowest index wins ties), advance the pointer and return to SCAN.
REQ-017 In DONE, res_valid SHALL be 1 with res_idx=best_idx, res_iou=best_iou and res_match=(a valid slot existed) && (best_iou <= iou_thresh); outputs stay stable until res_ready=1, then the block returns to IDLE.
REQ-018 With zero valid slots, the block SHALL present res_match=0, res_idx=0, res_iou=all-ones.
REQ-019 Valid_iou arriving outside WAIT SHALL be ignored.
REQ-020 The pointer SHALL be IDX_W+1 bits wide so that termination at NUM_HIST is detected without wrap-around.
REQ-021 Back-to-back operation: with res_valid&&res_ready in DONE, req_ready SHALL still be 0 that cycle; a new request is accepted no earlier than the next cycle.

Reset
REQ-022 With reset=1 at a clk edge the block SHALL enter IDLE from any state, including mid-scan, and abandon the in-flight request.
REQ-023 Reset SHALL clear all slot valid bits, best_iou to all-ones, best_idx to 0 and the pointer to 0; after reset, iou_start=0, res_valid=0, res_match=0, res_err=0 and req_ready=1.

Configuration
REQ-024 Macro OFLOW_IOU_SCHED_TIMEOUT_EN SHALL select the watchdog feature.
REQ-025 When defined, a counter SHALL run in WAIT; if TIMEOUT_CYC cycles pass without valid_iou, the slot counts as iou=all-ones (no best update), the sticky res_err for the request is set, and the block resumes SCAN.
REQ-026 When undefined, WAIT SHALL wait indefinitely and res_err SHALL be tied to 0.

Verification
REQ-027 Slots 0,2,5 valid, engine returns iou 0x100000, 0x080000, 0x080000, thresh 0x200000 -> three iou_start pulses, res_idx=2, res_iou=0x080000, res_match=1.
REQ-028 No valid slots, request accepted -> no iou_start, res_valid within NUM_HIST+2 cycles, res_match=0, res_iou=0x3FFFFF.
REQ-029 Single slot with iou 0x300000, thresh 0x200000 -> res_idx=0, res_match=0; res_ready held low 5 cycles -> outputs stable, req_ready=0.
REQ-030 reset asserted during WAIT of the second slot -> next cycle IDLE, req_ready=1, iou_start=0; all slots invalid afterwards.
REQ-031 hist_wr_en to slot 3 during SCAN -> write dropped; following request shows no access to slot 3.
REQ-032 Under OFLOW_IOU_SCHED_TIMEOUT_EN, the engine never answers slot 1 -> after 64 WAIT cycles scan resumes, res_err=1, best from the remaining slots.
